// File: rtl/tmr_bus_voter_ctrl.sv
// Triple-hart bitwise bus voter with per-hart consecutive-mismatch tracking
// and a TMR -> DMR -> FAIL degradation FSM.
module tmr_bus_voter_ctrl #(
    parameter int NCH        = 2,
    parameter int WIDTH      = 32,
    parameter int ERR_THRESH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   valid_i,
    input  logic [3*NCH*WIDTH-1:0] bus_i,
    input  logic                   clear_i,
    output logic [NCH*WIDTH-1:0]   voted_o,
    output logic                   voted_valid_o,
    output logic [2:0]             mismatch_o,
    output logic                   error_o,
    output logic [2:0]             hart_faulty_o,
    output logic [1:0]             mode_o,
    output logic                   fatal_o
);

    localparam int HW    = NCH * WIDTH;
    localparam int CNT_W = $clog2(ERR_THRESH + 1);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ERR_THRESH);

    typedef enum logic [1:0] {
        MODE_TMR  = 2'd0,
        MODE_DMR  = 2'd1,
        MODE_FAIL = 2'd2
    } mode_e;

    mode_e mode_q, mode_nxt;

    logic [HW-1:0]    hart [3];
    logic [HW-1:0]    maj_vec;
    logic [HW-1:0]    dmr_vec;
    logic [1:0]       lo_idx, hi_idx;
    logic             pair_mm;
    logic [2:0]       mm;
    logic [2:0]       reach;
    logic             any_reach, multi_reach;
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_nxt [3];

    logic [HW-1:0]    voted_p1;
    logic             vld_p1;
    logic [2:0]       mismatch_p1;
    logic [2:0]       faulty_q;

    function automatic logic [HW-1:0] maj3(input logic [HW-1:0] a,
                                           input logic [HW-1:0] b,
                                           input logic [HW-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == THRESH_C) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        for (int h = 0; h < 3; h++) begin
            hart[h] = bus_i[h*HW +: HW];
        end
    end

    assign maj_vec = maj3(hart[0], hart[1], hart[2]);

    // In DMR the surviving pair is the two non-faulty harts, lower index drives the bus
    always_comb begin
        lo_idx = 2'd0;
        hi_idx = 2'd1;
        if (faulty_q[0]) begin
            lo_idx = 2'd1;
            hi_idx = 2'd2;
        end else if (faulty_q[1]) begin
            lo_idx = 2'd0;
            hi_idx = 2'd2;
        end
    end

    assign dmr_vec = hart[lo_idx];
    assign pair_mm = |(hart[lo_idx] ^ hart[hi_idx]);

    always_comb begin
        mm = 3'b000;
        if (mode_q == MODE_DMR) begin
            mm[lo_idx] = pair_mm;
            mm[hi_idx] = pair_mm;
        end else begin
            for (int h = 0; h < 3; h++) begin
                mm[h] = |(hart[h] ^ maj_vec);
            end
        end
    end

    always_comb begin
        for (int h = 0; h < 3; h++) begin
            cnt_nxt[h] = cnt_q[h];
            reach[h]   = 1'b0;
            if (valid_i && (mode_q != MODE_FAIL) && !faulty_q[h]) begin
                cnt_nxt[h] = mm[h] ? sat_inc(cnt_q[h]) : '0;
                reach[h]   = (mode_q == MODE_TMR) && mm[h] &&
                             (sat_inc(cnt_q[h]) == THRESH_C);
            end
        end
    end

    assign any_reach   = |reach;
    assign multi_reach = (reach[0] & reach[1]) | (reach[0] & reach[2]) |
                         (reach[1] & reach[2]);

    always_comb begin
        mode_nxt = mode_q;
        unique case (mode_q)
            MODE_TMR: begin
                if (multi_reach)    mode_nxt = MODE_FAIL;
                else if (any_reach) mode_nxt = MODE_DMR;
            end
            MODE_DMR: begin
                if (valid_i && pair_mm) mode_nxt = MODE_FAIL;
            end
            MODE_FAIL: mode_nxt = MODE_FAIL;
            default:   mode_nxt = MODE_TMR;
        endcase
        if (clear_i) mode_nxt = MODE_TMR;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mode_q <= MODE_TMR;
        else         mode_q <= mode_nxt;
    end

    // Stage p1: registered vote, valid, mismatch flags and fault tracking
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            voted_p1    <= '0;
            vld_p1      <= 1'b0;
            mismatch_p1 <= 3'b000;
            faulty_q    <= 3'b000;
            for (int h = 0; h < 3; h++) cnt_q[h] <= '0;
        end else begin
            if (valid_i) voted_p1 <= (mode_q == MODE_DMR) ? dmr_vec : maj_vec;
            vld_p1 <= valid_i && (mode_nxt != MODE_FAIL);
            if (clear_i) begin
                mismatch_p1 <= 3'b000;
                faulty_q    <= 3'b000;
                for (int h = 0; h < 3; h++) cnt_q[h] <= '0;
            end else begin
                mismatch_p1 <= valid_i ? mm : 3'b000;
                faulty_q    <= faulty_q | reach;
                for (int h = 0; h < 3; h++) cnt_q[h] <= cnt_nxt[h];
            end
        end
    end

    assign voted_o       = voted_p1;
    assign voted_valid_o = vld_p1;
    assign mismatch_o    = mismatch_p1;
    assign error_o       = |mismatch_p1;
    assign hart_faulty_o = faulty_q;
    assign mode_o        = mode_q;
    assign fatal_o       = (mode_q == MODE_FAIL);

endmodule

// File: tb/tb_tmr_bus_voter_ctrl.sv
// Directed bench for tmr_bus_voter_ctrl: voting, fault counting, mode
// degradation, clear and asynchronous reset.
module tb_tmr_bus_voter_ctrl;

    localparam int NCH = 2;
    localparam int WIDTH = 32;
    localparam int HW = NCH * WIDTH;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              valid_i;
    logic [3*HW-1:0]   bus_i;
    logic              clear_i;
    logic [HW-1:0]     voted_o;
    logic              voted_valid_o;
    logic [2:0]        mismatch_o;
    logic              error_o;
    logic [2:0]        hart_faulty_o;
    logic [1:0]        mode_o;
    logic              fatal_o;

    int checks = 0;
    int failures = 0;

    localparam logic [HW-1:0] W  = {32'h0000_1234, 32'h0000_1234};
    localparam logic [HW-1:0] A  = {32'hCAFE_0001, 32'hBEEF_0002};
    localparam logic [HW-1:0] C  = {32'h0F0F_0F0F, 32'hF0F0_F0F0};
    localparam logic [HW-1:0] D  = {32'h1111_1111, 32'h2222_2222};
    localparam logic [HW-1:0] E  = {32'h5555_AAAA, 32'h0000_FFFF};

    tmr_bus_voter_ctrl #(.NCH(NCH), .WIDTH(WIDTH), .ERR_THRESH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .bus_i(bus_i),
        .clear_i(clear_i), .voted_o(voted_o), .voted_valid_o(voted_valid_o),
        .mismatch_o(mismatch_o), .error_o(error_o), .hart_faulty_o(hart_faulty_o),
        .mode_o(mode_o), .fatal_o(fatal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic v, input logic [HW-1:0] h0,
                         input logic [HW-1:0] h1, input logic [HW-1:0] h2);
        valid_i = v;
        bus_i   = {h2, h1, h0};
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; clear_i = 1'b0;
        drive(1'b1, W, W, W);
        step(); step();
        checks++; if (voted_o !== '0) begin failures++; $display("FAIL rst_voted got=%h exp=0", voted_o); end
        checks++; if (voted_valid_o !== 1'b0) begin failures++; $display("FAIL rst_vvalid got=%b exp=0", voted_valid_o); end
        checks++; if ({mismatch_o, error_o, hart_faulty_o, mode_o, fatal_o} !== 10'd0) begin
            failures++; $display("FAIL rst_status got=%b/%b/%b/%0d/%b exp=0", mismatch_o, error_o, hart_faulty_o, mode_o, fatal_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        drive(1'b0, W, W, W);
        step();
    endtask

    task automatic test_vote_clean();
        drive(1'b1, W, W, W);
        step();
        checks++; if (voted_o !== W) begin failures++; $display("FAIL clean_voted got=%h exp=%h", voted_o, W); end
        checks++; if (voted_valid_o !== 1'b1) begin failures++; $display("FAIL clean_vvalid got=%b exp=1", voted_valid_o); end
        checks++; if (mismatch_o !== 3'b000 || mode_o !== 2'd0) begin
            failures++; $display("FAIL clean_status got=%b/%0d exp=000/0", mismatch_o, mode_o);
        end
        drive(1'b0, A, A, A);
        step();
        checks++; if (voted_valid_o !== 1'b0 || voted_o !== W) begin
            failures++; $display("FAIL idle_hold got=%b/%h exp=0/%h", voted_valid_o, voted_o, W);
        end
    endtask

    task automatic test_transient();
        logic [HW-1:0] bad;
        bad = W ^ 64'h20;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W, bad, W);
            step();
            checks++; if (voted_o !== W) begin failures++; $display("FAIL trans_voted[%0d] got=%h exp=%h", i, voted_o, W); end
            checks++; if (mismatch_o !== 3'b010 || error_o !== 1'b1) begin
                failures++; $display("FAIL trans_mm[%0d] got=%b/%b exp=010/1", i, mismatch_o, error_o);
            end
        end
        drive(1'b1, W, W, W);
        step();
        checks++; if (mismatch_o !== 3'b000 || error_o !== 1'b0) begin
            failures++; $display("FAIL trans_clean got=%b/%b exp=000/0", mismatch_o, error_o);
        end
        // counter must have restarted: three more mismatches stay below threshold
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W, bad, W);
            step();
        end
        checks++; if (hart_faulty_o !== 3'b000 || mode_o !== 2'd0) begin
            failures++; $display("FAIL trans_nofault got=%b/%0d exp=000/0", hart_faulty_o, mode_o);
        end
        drive(1'b1, W, W, W);
        step();
    endtask

    task automatic test_degrade();
        logic [HW-1:0] bad;
        bad = W ^ 64'h1_0000_0000;
        drive(1'b1, W, W, bad); step();
        drive(1'b1, W, W, bad); step();
        drive(1'b0, W, W, bad); step();
        checks++; if (mismatch_o !== 3'b000 || voted_valid_o !== 1'b0) begin
            failures++; $display("FAIL gap_mm got=%b/%b exp=000/0", mismatch_o, voted_valid_o);
        end
        drive(1'b1, W, W, bad); step();
        checks++; if (hart_faulty_o !== 3'b000 || mode_o !== 2'd0) begin
            failures++; $display("FAIL deg_third got=%b/%0d exp=000/0", hart_faulty_o, mode_o);
        end
        drive(1'b1, W, W, bad); step();
        checks++; if (hart_faulty_o !== 3'b100 || mode_o !== 2'd1) begin
            failures++; $display("FAIL deg_fourth got=%b/%0d exp=100/1", hart_faulty_o, mode_o);
        end
        drive(1'b1, A, A, D); step();
        checks++; if (voted_o !== A || mismatch_o !== 3'b000 || mode_o !== 2'd1) begin
            failures++; $display("FAIL dmr_follow got=%h/%b/%0d exp=%h/000/1", voted_o, mismatch_o, mode_o, A);
        end
    endtask

    task automatic test_dmr_fail();
        logic [HW-1:0] a1;
        a1 = A ^ 64'h1;
        drive(1'b1, A, a1, a1); step();
        checks++; if (voted_o !== A) begin failures++; $display("FAIL dmr_voted got=%h exp=%h", voted_o, A); end
        checks++; if (mismatch_o !== 3'b011 || mode_o !== 2'd2 || fatal_o !== 1'b1 || voted_valid_o !== 1'b0) begin
            failures++; $display("FAIL dmr_fail got=%b/%0d/%b/%b exp=011/2/1/0", mismatch_o, mode_o, fatal_o, voted_valid_o);
        end
        drive(1'b1, C, C, D); step();
        checks++; if (voted_o !== C || voted_valid_o !== 1'b0 || mode_o !== 2'd2) begin
            failures++; $display("FAIL fail_hold got=%h/%b/%0d exp=%h/0/2", voted_o, voted_valid_o, mode_o, C);
        end
        clear_i = 1'b1;
        drive(1'b1, E ^ 64'h4, E, E); step();
        clear_i = 1'b0;
        checks++; if (mode_o !== 2'd0 || fatal_o !== 1'b0 || hart_faulty_o !== 3'b000 || mismatch_o !== 3'b000) begin
            failures++; $display("FAIL clear got=%0d/%b/%b/%b exp=0/0/000/000", mode_o, fatal_o, hart_faulty_o, mismatch_o);
        end
        checks++; if (voted_o !== E || voted_valid_o !== 1'b1) begin
            failures++; $display("FAIL clear_vote got=%h/%b exp=%h/1", voted_o, voted_valid_o, E);
        end
    endtask

    task automatic test_double_fault();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W ^ 64'h1, W ^ 64'h2, W); step();
        end
        checks++; if (mismatch_o !== 3'b011 || mode_o !== 2'd0 || voted_o !== W) begin
            failures++; $display("FAIL dbl_pre got=%b/%0d/%h exp=011/0/%h", mismatch_o, mode_o, voted_o, W);
        end
        drive(1'b1, W ^ 64'h1, W ^ 64'h2, W); step();
        checks++; if (mode_o !== 2'd2 || hart_faulty_o !== 3'b011 || fatal_o !== 1'b1) begin
            failures++; $display("FAIL dbl_fail got=%0d/%b/%b exp=2/011/1", mode_o, hart_faulty_o, fatal_o);
        end
        clear_i = 1'b1; drive(1'b0, W, W, W); step(); clear_i = 1'b0;
        checks++; if (mode_o !== 2'd0 || hart_faulty_o !== 3'b000) begin
            failures++; $display("FAIL dbl_clear got=%0d/%b exp=0/000", mode_o, hart_faulty_o);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W ^ 64'h8, W, W); step();
        end
        checks++; if (mismatch_o !== 3'b001) begin failures++; $display("FAIL ar_pre got=%b exp=001", mismatch_o); end
        #3 rst_ni = 1'b0;
        #1;
        checks++; if (voted_o !== '0 || voted_valid_o !== 1'b0 || mismatch_o !== 3'b000 || error_o !== 1'b0) begin
            failures++; $display("FAIL ar_now got=%h/%b/%b/%b exp=0/0/000/0", voted_o, voted_valid_o, mismatch_o, error_o);
        end
        step();
        #3 rst_ni = 1'b1;
        step();
        checks++; if (mismatch_o !== 3'b001 || hart_faulty_o !== 3'b000 || mode_o !== 2'd0) begin
            failures++; $display("FAIL ar_after got=%b/%b/%0d exp=001/000/0", mismatch_o, hart_faulty_o, mode_o);
        end
        drive(1'b1, W, W, W); step();
        checks++; if (mismatch_o !== 3'b000 || hart_faulty_o !== 3'b000) begin
            failures++; $display("FAIL ar_clean got=%b/%b exp=000/000", mismatch_o, hart_faulty_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, A, A, A); step();
        checks++; if (voted_o !== A) begin failures++; $display("FAIL b2b_a got=%h exp=%h", voted_o, A); end
        drive(1'b1, C, D, C); step();
        checks++; if (voted_o !== C || mismatch_o !== 3'b010) begin
            failures++; $display("FAIL b2b_c got=%h/%b exp=%h/010", voted_o, mismatch_o, C);
        end
        drive(1'b1, E, E, D); step();
        checks++; if (voted_o !== E || mismatch_o !== 3'b100 || voted_valid_o !== 1'b1) begin
            failures++; $display("FAIL b2b_e got=%h/%b/%b exp=%h/100/1", voted_o, mismatch_o, voted_valid_o, E);
        end
        drive(1'b0, W, W, W); step();
    endtask

    initial begin
        test_reset();
        test_vote_clean();
        test_transient();
        test_degrade();
        test_dmr_fail();
        test_double_fault();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
